// File: rtl/bit_zx_deser.sv
// Serial-to-parallel packer: gathers single bits LSB first into a W-bit word
// and offers it on a valid/ready output. A flush closes a partial word early
// and the unused upper bits read as zero.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   in_bit, in_valid  serial bit and its qualifier
//   in_ready          high while collecting (state COLLECT)
//   flush             close the current partial word (used only when in_ready)
//   out_data          assembled word, bit i = i-th accepted bit
//   out_len           number of valid bits in out_data (1..W while out_valid)
//   out_valid         high while a word is held (state HOLD)
//   out_ready         consumer takes the held word
module bit_zx_deser #(
    parameter int W = 8,
    localparam int LW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_bit,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output logic [W-1:0]  out_data,
    output logic [LW-1:0] out_len,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] HOLD    = 1'b1;

    localparam logic [LW-1:0] FULL = LW'(W);

    logic [0:0]    state;
    logic [LW-1:0] cnt;
    logic [W-1:0]  shreg;
    logic [LW-1:0] len;

    logic          accept;
    logic [LW-1:0] cnt_inc;
    logic [LW-1:0] n;
    logic [W-1:0]  bit_mask;
    logic [W-1:0]  shreg_set;

    // Handshake flags come only from the state register.
    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == HOLD);
    assign out_data  = shreg;
    assign out_len   = len;

    always_comb begin
        accept   = in_ready & in_valid;
        cnt_inc  = cnt + LW'(1);
        // A bit presented alongside flush is counted before the flush.
        n        = accept ? cnt_inc : cnt;
        bit_mask = {{(W-1){1'b0}}, 1'b1} << cnt;
        // Bits at and above cnt are always zero, so OR-ing places the bit.
        shreg_set = in_bit ? (shreg | bit_mask) : shreg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= COLLECT;
            cnt   <= '0;
            shreg <= '0;
            len   <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        shreg <= shreg_set;
                        cnt   <= cnt_inc;
                    end
                    // A filling bit makes a full word; any flush is absorbed.
                    if (accept && cnt_inc == FULL) begin
                        state <= HOLD;
                        len   <= FULL;
                    end else if (flush && n != '0) begin
                        state <= HOLD;
                        len   <= n;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= COLLECT;
                        cnt   <= '0;
                        shreg <= '0;
                        len   <= '0;
                    end
                end
                default: begin
                    state <= COLLECT;
                    cnt   <= '0;
                    shreg <= '0;
                    len   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_zx_deser.sv
// Bench for bit_zx_deser (W=8): table of words plus hand-written sequences
// for the bubble, hold, flush-at-zero and asynchronous reset cases.
module tb_bit_zx_deser;

    localparam int W  = 8;
    localparam int LW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_bit = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          flush = 1'b0;
    logic [W-1:0]  out_data;
    logic [LW-1:0] out_len;
    logic          out_valid;
    logic          out_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0]  d;
        logic [LW-1:0] l;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        int            nb;
        logic [31:0]   bits;
        int            mode;
        logic [W-1:0]  exp_d;
        logic [LW-1:0] exp_l;
    } vec_t;

    vec_t tv[9];

    bit_zx_deser #(.W(W)) dut (
        .clk(clk),
        .reset(reset),
        .in_bit(in_bit),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush(flush),
        .out_data(out_data),
        .out_len(out_len),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every word handed over is compared with the oldest
    // expected entry.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h/%0d expected none",
                         out_data, out_len);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("word_data", 32'(out_data), 32'(e.d));
                chk("word_len", 32'(out_len), 32'(e.l));
            end
        end
    end

    task automatic push(logic [W-1:0] d, logic [LW-1:0] l);
        exp_t e;
        e.d = d;
        e.l = l;
        sb.push_back(e);
    endtask

    // Present one cycle of input once in_ready is high; returns #1 after
    // the accepting edge.
    task automatic drive(logic iv, logic b, logic fl);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = iv;
        in_bit   = b;
        flush    = fl;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(int c);
        for (int i = 0; i < c; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;

        tv[0] = '{8, 32'h8D, 0, 8'h8D, 4'd8};
        tv[1] = '{3, 32'h03, 2, 8'h03, 4'd3};
        tv[2] = '{3, 32'h06, 1, 8'h06, 4'd3};
        tv[3] = '{8, 32'hFF, 1, 8'hFF, 4'd8};
        tv[4] = '{1, 32'h01, 2, 8'h01, 4'd1};
        tv[5] = '{1, 32'h00, 1, 8'h00, 4'd1};
        tv[6] = '{8, 32'h00, 0, 8'h00, 4'd8};
        tv[7] = '{5, 32'h16, 2, 8'h16, 4'd5};
        tv[8] = '{7, 32'h55, 2, 8'h55, 4'd7};

        idle(2);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_len", 32'(out_len), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        reset = 1'b0;
        idle(1);

        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < tv[i].nb; j++) begin
                logic fl;
                fl = (tv[i].mode == 1) && (j == tv[i].nb - 1);
                if (j == tv[i].nb - 1 && tv[i].mode != 2)
                    push(tv[i].exp_d, tv[i].exp_l);
                drive(1'b1, tv[i].bits[j], fl);
            end
            if (tv[i].mode == 2) begin
                push(tv[i].exp_d, tv[i].exp_l);
                drive(1'b0, 1'b0, 1'b1);
            end
        end
        idle(3);

        // Full word then one-cycle bubble.
        pat = 8'h8D;
        for (int j = 0; j < 8; j++) begin
            if (j == 7) push(8'h8D, 4'd8);
            drive(1'b1, pat[j], 1'b0);
        end
        chk("bubble_valid", 32'(out_valid), 1);
        chk("bubble_in_ready", 32'(in_ready), 0);
        idle(1);
        chk("after_valid", 32'(out_valid), 0);
        chk("after_in_ready", 32'(in_ready), 1);

        // Flush with nothing collected produces no word.
        drive(1'b0, 1'b0, 1'b1);
        chk("flush0_valid", 32'(out_valid), 0);
        idle(2);
        chk("flush0_valid2", 32'(out_valid), 0);
        pat = 8'hA5;
        for (int j = 0; j < 8; j++) begin
            if (j == 7) push(8'hA5, 4'd8);
            drive(1'b1, pat[j], 1'b0);
        end
        idle(3);

        // Partial word held under back-pressure; inputs ignored in HOLD.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        push(8'h03, 4'd3);
        drive(1'b0, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        flush    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", 32'(out_data), 32'h03);
            chk("hold_len", 32'(out_len), 3);
            chk("hold_in_ready", 32'(in_ready), 0);
            idle(1);
        end
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        idle(3);
        chk("hold_released", 32'(out_valid), 0);

        // Asynchronous reset mid-word (cnt=5).
        for (int j = 0; j < 5; j++) drive(1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_mid_data", 32'(out_data), 0);
        chk("arst_mid_in_ready", 32'(in_ready), 1);
        chk("arst_mid_len", 32'(out_len), 0);
        #1;
        reset = 1'b0;
        idle(1);
        pat = 8'h30;
        for (int j = 0; j < 8; j++) begin
            if (j == 7) push(8'h30, 4'd8);
            drive(1'b1, pat[j], 1'b0);
        end
        idle(3);

        // Asynchronous reset during HOLD; the held word is discarded.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        chk("pre_arst_valid", 32'(out_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_hold_valid", 32'(out_valid), 0);
        chk("arst_hold_data", 32'(out_data), 0);
        chk("arst_hold_len", 32'(out_len), 0);
        chk("arst_hold_in_ready", 32'(in_ready), 1);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        idle(1);
        drive(1'b1, 1'b0, 1'b0);
        push(8'h02, 4'd2);
        drive(1'b1, 1'b1, 1'b1);
        idle(4);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
